// File: rtl/falling_object_engine.sv
// Multi-object falling engine for the dodge game: LFSR spawn column, per-object
// fall speed, player collision, dodge scoring, hit counting and game-over latch.
module falling_object_engine #(
   parameter int          NUM_OBJ   = 2,
   parameter int          COLS      = 8,
   parameter int          ROWS      = 8,
   parameter int          COL_W     = 3,
   parameter int          ROW_W     = 3,
   parameter int          PERIOD_W  = 8,
   parameter int          HP_MAX    = 9,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                         CLK,
   input  logic                         Clear,
   input  logic                         tick,
   input  logic                         pause,
   input  logic [NUM_OBJ*PERIOD_W-1:0]  fall_period,
   input  logic [COL_W-1:0]             player_col,
   input  logic [ROW_W-1:0]             player_row,
   output logic [NUM_OBJ-1:0]           obj_active,
   output logic [NUM_OBJ*ROW_W-1:0]     obj_row,
   output logic [NUM_OBJ*COL_W-1:0]     obj_col,
   output logic [NUM_OBJ-1:0]           hit,
   output logic [NUM_OBJ-1:0]           dodge,
   output logic [3:0]                   hits,
   output logic [7:0]                   score,
   output logic                         game_over
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W:0]   COLS_W   = (COL_W + 1)'(COLS);
   localparam logic [3:0]       HP_LIM   = 4'(HP_MAX);

   typedef enum logic {S_IDLE = 1'b0, S_FALL = 1'b1} obj_state_t;

   obj_state_t            state_q [NUM_OBJ];
   obj_state_t            state_d [NUM_OBJ];
   logic [ROW_W-1:0]      row_q   [NUM_OBJ];
   logic [ROW_W-1:0]      row_d   [NUM_OBJ];
   logic [COL_W-1:0]      col_q   [NUM_OBJ];
   logic [COL_W-1:0]      col_d   [NUM_OBJ];
   logic [PERIOD_W-1:0]   cnt_q   [NUM_OBJ];
   logic [PERIOD_W-1:0]   cnt_d   [NUM_OBJ];
   logic [NUM_OBJ-1:0]    hit_q, hit_d, dodge_q, dodge_d;
   logic [3:0]            hits_q, hits_d;
   logic [7:0]            score_q, score_d;
   logic                  game_over_q, game_over_d;
   logic [15:0]           lfsr_q, lfsr_d;

   logic                  frozen, spawn_taken;
   logic [COL_W:0]        col_raw;
   logic [COL_W-1:0]      spawn_col;
   logic [PERIOD_W-1:0]   fp, fp_last;
   logic [3:0]            n_hit, n_dodge;
   logic [4:0]            hit_sum;
   logic [8:0]            score_sum;

   // Galois LFSR x^16+x^14+x^13+x^11, free-running even while frozen
   always_comb begin
      lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      col_raw   = {1'b0, lfsr_q[COL_W-1:0]};
      spawn_col = (col_raw >= COLS_W) ? COL_W'(col_raw - COLS_W) : col_raw[COL_W-1:0];
   end

   assign frozen = pause | game_over_q;

   always_comb begin
      spawn_taken = 1'b0;
      fp          = '0;
      fp_last     = '0;
      hit_d       = '0;
      dodge_d     = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         state_d[i] = state_q[i];
         row_d[i]   = row_q[i];
         col_d[i]   = col_q[i];
         cnt_d[i]   = cnt_q[i];
      end
      if (!frozen) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            fp      = fall_period[i*PERIOD_W +: PERIOD_W];
            fp_last = (fp == '0) ? '0 : fp - 1'b1;
            if (state_q[i] == S_FALL) begin
               // a strike wins over any step or dodge in the same cycle
               if (row_q[i] == player_row && col_q[i] == player_col) begin
                  state_d[i] = S_IDLE;
                  hit_d[i]   = 1'b1;
               end else if (tick) begin
                  if (cnt_q[i] >= fp_last) begin
                     cnt_d[i] = '0;
                     if (row_q[i] == ROW_LAST) begin
                        state_d[i] = S_IDLE;
                        dodge_d[i] = 1'b1;
                     end else begin
                        row_d[i] = row_q[i] + 1'b1;
                     end
                  end else begin
                     cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end
            end else if (tick && !spawn_taken) begin
               spawn_taken = 1'b1;
               state_d[i]  = S_FALL;
               row_d[i]    = '0;
               col_d[i]    = spawn_col;
               cnt_d[i]    = '0;
            end
         end
      end
   end

   always_comb begin
      n_hit   = '0;
      n_dodge = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         n_hit   = n_hit + 4'(hit_d[i]);
         n_dodge = n_dodge + 4'(dodge_d[i]);
      end
      hit_sum     = 5'(hits_q) + 5'(n_hit);
      hits_d      = (hit_sum >= 5'(HP_MAX)) ? HP_LIM : hit_sum[3:0];
      score_sum   = 9'(score_q) + 9'(n_dodge);
      score_d     = score_sum[8] ? 8'hFF : score_sum[7:0];
      game_over_d = game_over_q | (hits_q >= HP_LIM);
   end

   always_ff @(posedge CLK or negedge Clear) begin
      if (!Clear) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            state_q[i] <= S_IDLE;
            row_q[i]   <= '0;
            col_q[i]   <= '0;
            cnt_q[i]   <= '0;
         end
         hit_q       <= '0;
         dodge_q     <= '0;
         hits_q      <= '0;
         score_q     <= '0;
         game_over_q <= 1'b0;
         lfsr_q      <= LFSR_SEED;
      end else begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            state_q[i] <= state_d[i];
            row_q[i]   <= row_d[i];
            col_q[i]   <= col_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         hit_q       <= hit_d;
         dodge_q     <= dodge_d;
         hits_q      <= hits_d;
         score_q     <= score_d;
         game_over_q <= game_over_d;
         lfsr_q      <= lfsr_d;
      end
   end

   for (genvar g = 0; g < NUM_OBJ; g++) begin : g_out
      assign obj_active[g]               = (state_q[g] == S_FALL);
      assign obj_row[g*ROW_W +: ROW_W]   = row_q[g];
      assign obj_col[g*COL_W +: COL_W]   = col_q[g];
   end

   assign hit       = hit_q;
   assign dodge     = dodge_q;
   assign hits      = hits_q;
   assign score     = score_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_falling_object_engine.sv
// Directed bench for falling_object_engine: a per-cycle vector table for the
// basic spawn/fall/dodge flow plus hand sequences for hits, pause and reset.
module tb_falling_object_engine;

   localparam int NUM_OBJ = 2;

   logic        CLK = 1'b0;
   logic        Clear = 1'b0;
   logic        tick = 1'b0;
   logic        pause = 1'b0;
   logic [15:0] fall_period = 16'h0101;
   logic [2:0]  player_col = 3'd0;
   logic [2:0]  player_row = 3'd7;
   logic [1:0]  obj_active;
   logic [5:0]  obj_row;
   logic [5:0]  obj_col;
   logic [1:0]  hit;
   logic [1:0]  dodge;
   logic [3:0]  hits;
   logic [7:0]  score;
   logic        game_over;

   int n_tests = 0;
   int n_fail  = 0;

   falling_object_engine #(
      .NUM_OBJ(NUM_OBJ), .COLS(8), .ROWS(8), .COL_W(3), .ROW_W(3),
      .PERIOD_W(8), .HP_MAX(9), .LFSR_SEED(16'hACE1)
   ) dut (
      .CLK(CLK), .Clear(Clear), .tick(tick), .pause(pause),
      .fall_period(fall_period), .player_col(player_col), .player_row(player_row),
      .obj_active(obj_active), .obj_row(obj_row), .obj_col(obj_col),
      .hit(hit), .dodge(dodge), .hits(hits), .score(score), .game_over(game_over)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   // reference spawn-column source: 16-bit Galois LFSR, taps 16,14,13,11
   logic [15:0] m_lfsr;
   always @(posedge CLK or negedge Clear) begin
      if (!Clear) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // COLS is 8, so the low three bits never need wrapping
   function automatic logic [2:0] exp_col();
      return m_lfsr[2:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic cyc(input logic t);
      tick = t;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Clear = 1'b0;
      tick  = 1'b0;
      pause = 1'b0;
      @(posedge CLK);
      #1;
      check("rst_active", obj_active, 0);
      check("rst_pos", {obj_row, obj_col}, 0);
      check("rst_pulses", {hit, dodge}, 0);
      check("rst_counts", {hits, score, game_over}, 0);
      Clear = 1'b1;
   endtask

   typedef struct packed {
      logic       tk;
      logic [1:0] act;
      logic [2:0] r0;
      logic [2:0] r1;
      logic [2:0] c0;
      logic [2:0] c1;
      logic [1:0] cm;
      logic [1:0] dg;
      logic [7:0] sc;
   } vec_t;

   vec_t tv [13];

   initial begin
      // after-edge expectations, cycles 1..13 after reset release, period 1
      tv[0]  = '{1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 8'd0};
      tv[1]  = '{1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 8'd0};
      tv[2]  = '{1'b1, 2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 2'b01, 2'b00, 8'd0};
      tv[3]  = '{1'b1, 2'b11, 3'd1, 3'd0, 3'd0, 3'd4, 2'b11, 2'b00, 8'd0};
      tv[4]  = '{1'b1, 2'b11, 3'd2, 3'd1, 3'd0, 3'd4, 2'b11, 2'b00, 8'd0};
      tv[5]  = '{1'b1, 2'b11, 3'd3, 3'd2, 3'd0, 3'd4, 2'b11, 2'b00, 8'd0};
      tv[6]  = '{1'b1, 2'b11, 3'd4, 3'd3, 3'd0, 3'd4, 2'b11, 2'b00, 8'd0};
      tv[7]  = '{1'b1, 2'b11, 3'd5, 3'd4, 3'd0, 3'd4, 2'b11, 2'b00, 8'd0};
      tv[8]  = '{1'b1, 2'b11, 3'd6, 3'd5, 3'd0, 3'd4, 2'b11, 2'b00, 8'd0};
      tv[9]  = '{1'b1, 2'b11, 3'd7, 3'd6, 3'd0, 3'd4, 2'b11, 2'b00, 8'd0};
      tv[10] = '{1'b1, 2'b10, 3'd7, 3'd7, 3'd0, 3'd4, 2'b11, 2'b01, 8'd1};
      tv[11] = '{1'b1, 2'b01, 3'd0, 3'd7, 3'd0, 3'd4, 2'b10, 2'b10, 8'd2};
      tv[12] = '{1'b0, 2'b01, 3'd0, 3'd7, 3'd0, 3'd4, 2'b10, 2'b00, 8'd2};

      // table: spawn order, columns, period-1 fall, dodge pulses, score
      fall_period = {8'd1, 8'd1};
      player_row  = 3'd7;
      player_col  = 3'd2;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         cyc(tv[i].tk);
         check($sformatf("t%0d_active", i), obj_active, tv[i].act);
         check($sformatf("t%0d_row0", i), obj_row[2:0], tv[i].r0);
         check($sformatf("t%0d_row1", i), obj_row[5:3], tv[i].r1);
         if (tv[i].cm[0]) check($sformatf("t%0d_col0", i), obj_col[2:0], tv[i].c0);
         if (tv[i].cm[1]) check($sformatf("t%0d_col1", i), obj_col[5:3], tv[i].c1);
         check($sformatf("t%0d_dodge", i), dodge, tv[i].dg);
         check($sformatf("t%0d_score", i), score, tv[i].sc);
         check($sformatf("t%0d_hit", i), hit, 0);
      end

      // period 3: one row per third tick, idle cycles do not count
      fall_period = {8'd255, 8'd3};
      player_row  = 3'd7;
      player_col  = 3'd1;
      do_reset();
      cyc(1'b0); cyc(1'b0); cyc(1'b1);
      check("p3_spawn_active", obj_active[0], 1);
      check("p3_spawn_col", obj_col[2:0], 0);
      for (int r = 1; r < 8; r++) begin
         cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0);
         check($sformatf("p3_hold_r%0d", r), obj_row[2:0], r - 1);
         cyc(1'b1);
         check($sformatf("p3_step_r%0d", r), obj_row[2:0], r);
         cyc(1'b0);
      end
      cyc(1'b1); cyc(1'b1);
      check("p3_pre_dodge", {obj_active[0], dodge}, 3'b100);
      cyc(1'b1);
      check("p3_dodge", dodge, 2'b01);
      check("p3_dodge_active", obj_active, 2'b10);
      check("p3_score", score, 1);
      cyc(1'b0);
      check("p3_dodge_pulse", dodge, 0);
      check("p3_score_hold", score, 1);
      begin
         logic [2:0] pc;
         pc = exp_col();
         cyc(1'b1);
         check("p3_respawn", {obj_active, obj_row[2:0]}, {2'b11, 3'd0});
         check("p3_respawn_col", obj_col[2:0], pc);
      end

      // falling onto the player, then the player stepping into an object
      fall_period = {8'd255, 8'd1};
      player_row  = 3'd6;
      player_col  = 3'd0;
      do_reset();
      cyc(1'b0); cyc(1'b0); cyc(1'b1);
      for (int k = 1; k <= 6; k++) cyc(1'b1);
      check("hit_row6", obj_row[2:0], 6);
      check("hit_not_yet", hit, 0);
      cyc(1'b1);
      check("hit_pulse", hit, 2'b01);
      check("hit_active", obj_active, 2'b10);
      check("hit_count", hits, 1);
      check("hit_no_score", {dodge, score}, 0);
      cyc(1'b0);
      check("hit_pulse_end", hit, 0);
      check("hit_row_hold", obj_row[2:0], 6);
      check("hit_count_hold", hits, 1);
      player_row = 3'd0;
      player_col = 3'd4;
      cyc(1'b0);
      check("walkin_hit", hit, 2'b10);
      check("walkin_count", hits, 2);
      check("walkin_active", obj_active, 0);

      // both objects share column 4 and reach row 6 together
      fall_period = {8'd1, 8'd2};
      player_row  = 3'd6;
      player_col  = 3'd4;
      do_reset();
      cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
      check("dbl_col0", obj_col[2:0], 4);
      cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
      check("dbl_col1", obj_col[5:3], 4);
      check("dbl_rows0", obj_row, 0);
      fall_period = {8'd1, 8'd1};
      for (int k = 1; k <= 6; k++) cyc(1'b1);
      check("dbl_rows6", obj_row, {3'd6, 3'd6});
      cyc(1'b0);
      check("dbl_hit", hit, 2'b11);
      check("dbl_hits", hits, 2);
      check("dbl_active", obj_active, 0);

      // nine strikes at row 0 latch game over
      fall_period = {8'd255, 8'd255};
      player_row  = 3'd0;
      do_reset();
      for (int h = 1; h <= 9; h++) begin
         player_col = exp_col();
         cyc(1'b1);
         check($sformatf("go_spawn%0d", h), {obj_active, hit}, 4'b0100);
         cyc(1'b0);
         check($sformatf("go_hit%0d", h), {hit, hits}, {2'b01, 4'(h)});
         check($sformatf("go_flag%0d", h), game_over, 0);
      end
      cyc(1'b0);
      check("go_latch", game_over, 1);
      for (int k = 0; k < 3; k++) begin
         player_col = exp_col();
         cyc(1'b1);
         cyc(1'b0);
      end
      check("go_frozen", {obj_active, hit, dodge}, 0);
      check("go_hits_sat", hits, 9);
      check("go_sticky", game_over, 1);
      #3 Clear = 1'b0;
      #1;
      check("go_clear", {hits, game_over}, 0);
      @(posedge CLK);
      #1;
      Clear = 1'b1;

      // pause mid-fall freezes everything; clear mid-fall restores reset state
      fall_period = {8'd255, 8'd3};
      player_row  = 3'd7;
      player_col  = 3'd1;
      do_reset();
      cyc(1'b0); cyc(1'b0); cyc(1'b1); cyc(1'b1);
      pause = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc(1'b1);
         check($sformatf("pause_active%0d", k), obj_active, 2'b11);
         check($sformatf("pause_pulses%0d", k), {hit, dodge}, 0);
      end
      check("pause_rows", obj_row, 0);
      check("pause_score", {hits, score}, 0);
      pause = 1'b0;
      cyc(1'b1);
      check("unpause_cnt", obj_row[2:0], 0);
      cyc(1'b1);
      check("unpause_step", obj_row[2:0], 1);
      #3 Clear = 1'b0;
      #1;
      check("midclr_active", obj_active, 0);
      check("midclr_pos", {obj_row, obj_col}, 0);
      @(posedge CLK);
      #1;
      Clear = 1'b1;
      cyc(1'b0);
      check("postclr_wait", obj_active, 0);
      cyc(1'b1);
      check("postclr_spawn", obj_active, 2'b01);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
